// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter in front of a single-port data memory. Requester 0
//   is the core load/store path, requester 1 the loader/debug path. Each
//   transaction takes three cycles: IDLE (arbitrate and latch), ACCESS
//   (drive the memory) and RESP (return data and error).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   r{0,1}_req/_we/_addr/_wdata request valid, write flag, byte address, data
//   r{0,1}_gnt                  grant pulse, high for the whole ACCESS cycle
//   r{0,1}_rvalid/_rdata/_err   completion pulse with read data and error
//   mem_address/_write_data     memory address and write data
//   mem_memorywrite/_memoryread memory write strobe and read enable
//   mem_read_data               combinational read data from the memory
//   busy                        high whenever the FSM is not in IDLE
//   txn_count                   completed transactions, wraps at 16 bits
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memorywrite,
    output logic              mem_memoryread,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic [15:0]       txn_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic              last_grant_reg;   // requester granted most recently
    logic              sel_reg;          // requester owning the current transaction
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [15:0]       txn_count_reg;

    logic any_req;
    logic winner;
    logic legal;

    assign any_req = r0_req | r1_req;
    // On a tie the requester that did not win last time gets the slot;
    // otherwise whoever is asking wins (r1 alone -> 1, r0 alone -> 0).
    assign winner  = (r0_req & r1_req) ? ~last_grant_reg : ~r0_req;

    // Legality is judged on the latched address so the memory side never
    // sees a combinational path from the requester inputs.
    assign legal   = (addr_reg[2:0] == 3'b000) && (addr_reg <= LAST_ADDR);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        r0_gnt          = 1'b0;
        r1_gnt          = 1'b0;
        r0_rvalid       = 1'b0;
        r1_rvalid       = 1'b0;
        r0_rdata        = '0;
        r1_rdata        = '0;
        r0_err          = 1'b0;
        r1_err          = 1'b0;
        mem_address     = '0;
        mem_write_data  = '0;
        mem_memorywrite = 1'b0;
        mem_memoryread  = 1'b0;
        busy            = (state_reg != IDLE);
        case (state_reg)
            ACCESS: begin
                r0_gnt = ~sel_reg;
                r1_gnt = sel_reg;
                if (legal) begin
                    mem_address     = addr_reg;
                    mem_memoryread  = ~we_reg;
                    mem_memorywrite = we_reg;
                    if (we_reg) mem_write_data = wdata_reg;
                end
            end
            RESP: begin
                if (sel_reg) begin
                    r1_rvalid = 1'b1;
                    r1_rdata  = rdata_reg;
                    r1_err    = ~legal;
                end else begin
                    r0_rvalid = 1'b1;
                    r0_rdata  = rdata_reg;
                    r0_err    = ~legal;
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;     // requester 0 wins the first tie
            sel_reg        <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            txn_count_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        last_grant_reg <= winner;
                        sel_reg        <= winner;
                        we_reg         <= winner ? r1_we    : r0_we;
                        addr_reg       <= winner ? r1_addr  : r0_addr;
                        wdata_reg      <= winner ? r1_wdata : r0_wdata;
                    end
                end
                ACCESS: begin
                    // Writes and illegal accesses return zero data.
                    rdata_reg <= (legal && !we_reg) ? mem_read_data : '0;
                end
                RESP: begin
                    txn_count_reg <= txn_count_reg + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign txn_count = txn_count_reg;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64: width of the requester and memory address.
REQ-002 Parameter DATA_W, default 64: width of the data word, 8 byte lanes.
REQ-003 Parameter MEM_BYTES, default 64: size of the data memory in bytes; the last legal word address is MEM_BYTES-8.
REQ-004 Port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Ports r0_req/r1_req  input  1  request valid from requester 0 (core load/store) and requester 1 (loader/debug).
REQ-007 Ports r0_we/r1_we  input  1  1 means write, 0 means read.
REQ-008 Ports r0_addr/r1_addr  input  ADDR_W  byte address of the 8-byte word.
REQ-009 Ports r0_wdata/r1_wdata  input  DATA_W  write data, little-endian.
REQ-010 Ports r0_gnt/r1_gnt  output  1  one-cycle grant pulse; the request fields are latched.
REQ-011 Ports r0_rvalid/r1_rvalid  output  1  one-cycle completion pulse, for both read and write.
REQ-012 Ports r0_rdata/r1_rdata  output  DATA_W  read data; valid only while the matching rvalid is high.
REQ-013 Ports r0_err/r1_err  output  1  error flag; qualified by the matching rvalid.
REQ-014 Port mem_address  output  ADDR_W  address to the data memory.
REQ-015 Port mem_write_data  output  DATA_W  write data to the data memory.
REQ-016 Port mem_memorywrite  output  1  write strobe; the memory commits on the rising clk edge.
REQ-017 Port mem_memoryread  output  1  read enable to the data memory.
REQ-018 Port mem_read_data  input  DATA_W  combinational read data from the data memory.
REQ-019 Port busy  output  1  high in any state other than IDLE.
REQ-020 Port txn_count  output  16  count of completed transactions; wraps at 16'hFFFF to 0.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and RESP; IDLE->ACCESS when any request is high at the edge; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-022 In IDLE with exactly one request high, that requester SHALL win; with both high, the requester not in last_grant SHALL win (round-robin).
REQ-023 On IDLE->ACCESS the block SHALL latch the winner's we, addr and wdata, set last_grant to the winner, and assert that requester's gnt for the whole ACCESS cycle only.
REQ-024 A requester SHALL hold req and its fields stable until gnt, and SHALL drop req by the edge that ends ACCESS; a req still high in IDLE is a new request.
REQ-025 All mem_* outputs SHALL decode only from the registered state and latched fields, with no combinational path from r*_ inputs.
REQ-026 In ACCESS with a legal read, mem_memoryread=1 and mem_read_data SHALL be captured into the rdata register at the closing edge.
REQ-027 In ACCESS with a legal write, mem_memorywrite=1 and mem_write_data=latched wdata for exactly one cycle.
REQ-028 A request is illegal if addr[2:0]!=0 or addr>MEM_BYTES-8; for an illegal request, both strobes SHALL stay 0, rdata SHALL be 0 and err SHALL be 1 in RESP.
REQ-029 In RESP the granted requester's rvalid SHALL be 1 for one cycle with rdata and err, and txn_count SHALL increment at the edge that ends RESP, including errored transactions.
REQ-030 Outside ACCESS, mem_memorywrite=0, mem_memoryread=0, mem_address=0 and mem_write_data=0; rdata outputs of the non-granted requester SHALL read 0.
REQ-031 Latency SHALL be: req sampled at edge N, gnt in cycle N+1, rvalid in cycle N+2; throughput is at most one transaction per 3 cycles.

Reset
REQ-032 When rst_n=0, immediately and asynchronously: state=IDLE; all gnt, rvalid, err, rdata, mem_* strobes, busy and txn_count = 0; last_grant=1, so requester 0 wins the first tie.
REQ-033 Reset asserted during ACCESS SHALL drop mem_memorywrite before the next edge; the in-flight write is not committed and no rvalid is issued.

Verification
REQ-034 Read of memory word 1: r0 read addr=8 with the memory holding 64'd2 -> r0_gnt at N+1, mem_memoryread=1 in ACCESS, r0_rvalid at N+2 with r0_rdata=2 and r0_err=0.
REQ-035 Write then read back: r1 write addr=16, wdata=64'hDEADBEEF00000003, then r1 read addr=16 -> read returns the same value; mem_memorywrite high for exactly 1 cycle.
REQ-036 Contention: r0 and r1 held high continuously -> grants alternate r0, r1, r0, r1; each rvalid arrives 1 cycle after its gnt; txn_count=4 after four transactions.
REQ-037 Illegal access: r0 read addr=4, then r0 read addr=64 -> no strobes, r0_rvalid with r0_err=1 and r0_rdata=0; txn_count still increments.
REQ-038 Mid-write reset: rst_n=0 during the ACCESS cycle of a write to addr=24 -> memory word at 24 unchanged, all outputs 0 at once, and the first request after reset is granted normally.
